// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard and forwarding controller for a 5-stage RV32I pipeline.
// Handles RAW forwarding, load-use stalls, branch/jump flushes, a multi-cycle
// execute unit that holds Execute for MC_LAT cycles, and a data memory that can
// insert wait states by freezing the pipeline from Memory backwards.
module hazard_unit_mc #(
    parameter int          REG_AW   = 5,
    parameter int          MC_LAT   = 4,
    parameter logic [1:0]  LOAD_RES = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [1:0]        result_src_e,
    input  logic              pc_src_e,
    input  logic              mc_op_e,
    input  logic              dmem_ready_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              mc_busy
);

    // Counter wide enough to hold MC_LAT-2, never narrower than one bit.
    localparam int CNT_W = ($clog2(MC_LAT) > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'((MC_LAT > 2) ? (MC_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mc_state_e;

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_stall_raw;
    logic             mc_stall;
    logic             mem_wait;
    logic             lw_stall;

    assign mem_wait = !dmem_ready_m;

    assign lw_stall = (result_src_e == LOAD_RES) && (rd_e != '0) &&
                      ((rs1_d == rd_e) || (rs2_d == rd_e));

    // Operand forwarding: Memory-stage result has priority over Writeback; x0 never forwards.
    assign fwd_a_e = (reg_write_m && (rd_m != '0) && (rs1_e == rd_m)) ? 2'b10 :
                     (reg_write_w && (rd_w != '0) && (rs1_e == rd_w)) ? 2'b01 : 2'b00;
    assign fwd_b_e = (reg_write_m && (rd_m != '0) && (rs2_e == rd_m)) ? 2'b10 :
                     (reg_write_w && (rd_w != '0) && (rs2_e == rd_w)) ? 2'b01 : 2'b00;

    // FSM state and countdown registers for the multi-cycle execute window.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multi-cycle FSM next state; a memory wait freezes the window in place.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        mc_stall_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mc_op_e && !mem_wait && (MC_LAT > 1)) begin
                    mc_stall_raw = 1'b1;
                    if (MC_LAT == 2) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_START;
                    end
                end
            end
            S_RUN: begin
                mc_stall_raw = 1'b1;
                if (!mem_wait) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                // The op proceeds out of Execute this cycle unless Memory is waiting.
                if (!mem_wait) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // An op held in reset must not stall the pipeline.
    assign mc_stall = mc_stall_raw && !rst;
    assign mc_busy  = (state_q != S_IDLE) || mc_stall;

    // Stall/flush priority: memory wait, then multi-cycle hold, then load-use/branch.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (mem_wait) begin
            // Execute is frozen, so a resolved branch there must not flush yet.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_e = lw_stall || pc_src_e;
            flush_d = pc_src_e;
        end
    end

endmodule
